first_system_timer_ctrl_master: RTL and testbench
=================================================

// Module: first_system_timer_ctrl_master
// PURPOSE
//  Avalon-MM master (initiator) driving the interval timer's 16-bit register slave port.
//  Turns single host commands into timer bus sequences: configure+start, stop, snapshot, clear.
//  Optionally services the timer irq in hardware.
//  Sits between a host/control FSM and the timer slave in first_system.
// PARAMETERS
//  CNT_W        16  width of event_count (wraps modulo 2^CNT_W)
//  RD_LATENCY    1  cycles from read address to valid avm_readdata; fixed, the timer registers readdata
// PORTS
//  clk            in   1   system clock; single clock domain
//  reset_n        in   1   reset, synchronous, active-low
//  cmd_valid      in   1   host command request
//  cmd_ready      out  1   FSM idle and no irq service pending
//  cmd_op         in   2   0 START, 1 STOP, 2 SNAPSHOT, 3 CLEAR
//  cmd_period     in   32  START: timer period (timer counts cmd_period+1 clocks)
//  cmd_continuous in   1   START: CONT control bit
//  cmd_irq_en     in   1   START: ITO control bit
//  cmd_done       out  1   one-cycle pulse when a command sequence completes
//  snap_value     out  32  last snapshot {snap_h,snap_l}; held until the next SNAPSHOT
//  avm_address    out  3   timer register index
//  avm_chipselect out  1   bus access this cycle
//  avm_write_n    out  1   0 = write; 1 with chipselect = read
//  avm_writedata  out  16  write data
//  avm_readdata   in   16  read data, valid RD_LATENCY after the address
//  irq            in   1   timer interrupt, level
//  tick           out  1   one-cycle pulse per serviced timeout
//  event_count    out  CNT_W  serviced timeout count
// BEHAVIOUR
//  - Reset: state IDLE. chipselect 0, write_n 1, address 0, writedata 0. cmd_done 0, tick 0.
//    snap_value 0, event_count 0. Reset mid-sequence abandons it; no partial bus cycle follows.
//  - Handshake: command accepted on the clk edge where cmd_valid && cmd_ready.
//    Operands are latched at acceptance; cmd_ready stays 0 until the sequence returns to IDLE.
//  - The slave has no waitrequest. Every access is one cycle, with chipselect high for exactly that cycle.
//  - Sequences, back-to-back one access per cycle:
//    START: WR_PL(a2, period[15:0]), WR_PH(a3, period[31:16]),
//      then WR_CTRL(a1, {STOP=0, START=1, CONT, ITO}).
//      3 bus cycles. cmd_done pulses in the cycle after WR_CTRL.
//    STOP: WR_STOP(a1, 16'h0008); done the next cycle.
//    CLEAR: WR_STAT(a0, 16'h0000); done the next cycle.
//    SNAPSHOT: WR_SNAP(a4, any data), RD_SL(read a4), RD_SH(read a5, capture snap_l from readdata),
//      RD_LAST(no access, capture snap_h).
//      snap_value updates at the end of RD_LAST; cmd_done pulses in that same cycle.
//  - Control bit map: ITO=0, CONT=1, START=2, STOP=3. Upper writedata bits are 0.
//  - Between accesses: chipselect 0, write_n 1. address and writedata hold their last values.
//  - IRQ service (macro on): in IDLE, irq==1 takes priority over a pending cmd_valid.
//    SVC_WR writes a0 = 0. tick pulses and event_count increments in the cycle after SVC_WR.
//    The slave drops irq by then, so the same event is never double-counted.
//    irq asserted mid-sequence is deferred until IDLE. cmd_ready = IDLE && !irq.
//  - An irq that re-asserts immediately, with no IDLE gap, is serviced again. Host commands can starve;
//    this is accepted and documented.
//  - event_count wraps from 2^CNT_W-1 to 0.
// CONFIGURATION
//  TIMER_CTRL_MASTER_IRQ_SVC_EN
//   defined: IRQ service as above.
//   undefined: irq ignored; tick=0, event_count=0. cmd_ready = (state==IDLE).
//    Host clears status with CLEAR.
// STRUCTURE
//  Package first_system_timer_pkg holds:
//    register indices (STATUS 0, CONTROL 1, PERIODL 2, PERIODH 3, SNAPL 4, SNAPH 5);
//    control bit positions; cmd_op encodings; FSM state enum.
//  Single flat FSM plus datapath registers. No sub-module warranted.
// TESTING (bench includes a timer slave model with registered readdata and irq)
//  - START period=32'h0001_86A0, cont=1, ite=1 -> writes a2=86A0, a3=0001, a1=0007 on consecutive cycles;
//    cmd_done in the 4th cycle.
//  - SNAPSHOT with model counter 32'h1234_5678 -> snap_value=32'h1234_5678; done 4 cycles after acceptance.
//  - irq and cmd_valid(STOP) rise together in IDLE -> a0 written first, tick pulses, event_count=1;
//    then a1=0008.
//  - irq during a START sequence -> START completes uninterrupted; service write immediately after;
//    event_count +1 exactly once.
//  - reset_n=0 in the cycle RD_SL is on the bus -> next cycle chipselect=0, snap_value=0, cmd_ready=1;
//    no RD_SH access.
//  - Macro undefined, irq held high 20 cycles -> no a0 write, tick never pulses, cmd_ready stays 1.

Source files
------------

// File: rtl/first_system_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : first_system_timer_pkg
// Purpose  : Timer register map, control bits, command opcodes, master FSM states
// Revision : 1.0  initial release
// ============================================================================
package first_system_timer_pkg;

  localparam logic [2:0] c_reg_status  = 3'd0;
  localparam logic [2:0] c_reg_control = 3'd1;
  localparam logic [2:0] c_reg_periodl = 3'd2;
  localparam logic [2:0] c_reg_periodh = 3'd3;
  localparam logic [2:0] c_reg_snapl   = 3'd4;
  localparam logic [2:0] c_reg_snaph   = 3'd5;

  localparam int c_ctrl_ito   = 0;
  localparam int c_ctrl_cont  = 1;
  localparam int c_ctrl_start = 2;
  localparam int c_ctrl_stop  = 3;

  localparam logic [1:0] c_op_start    = 2'd0;
  localparam logic [1:0] c_op_stop     = 2'd1;
  localparam logic [1:0] c_op_snapshot = 2'd2;
  localparam logic [1:0] c_op_clear    = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_PL   = 4'd1,
    ST_WR_PH   = 4'd2,
    ST_WR_CTRL = 4'd3,
    ST_WR_STOP = 4'd4,
    ST_WR_STAT = 4'd5,
    ST_WR_SNAP = 4'd6,
    ST_RD_SL   = 4'd7,
    ST_RD_SH   = 4'd8,
    ST_RD_LAST = 4'd9,
    ST_SVC_WR  = 4'd10
  } state_t;

  function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                            input logic cont, input logic ito);
    logic [15:0] w_word;
    w_word               = 16'h0000;
    w_word[c_ctrl_stop]  = stop;
    w_word[c_ctrl_start] = start;
    w_word[c_ctrl_cont]  = cont;
    w_word[c_ctrl_ito]   = ito;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/first_system_timer_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module   : first_system_timer_ctrl_master
// Purpose  : Avalon-MM master turning host commands into interval-timer register
//            sequences. Optional hardware irq service: TIMER_CTRL_MASTER_IRQ_SVC_EN
// Revision : 1.0  initial release
// ============================================================================
module first_system_timer_ctrl_master
  import first_system_timer_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_period,
  input  logic             cmd_continuous,
  input  logic             cmd_irq_en,
  output logic             cmd_done,
  output logic [31:0]      snap_value,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  input  logic             irq,
  output logic             tick,
  output logic [CNT_W-1:0] event_count
);

  if (RD_LATENCY != 1) begin : g_rd_latency_check
    $error("first_system_timer_ctrl_master supports RD_LATENCY == 1 only");
  end

  state_t      r_state;
  state_t      w_next_state;
  logic        w_svc_req;
  logic        w_accept;

  logic [15:0] r_period_h;
  logic        r_cont;
  logic        r_ito;

  logic        w_bus_cs;
  logic        w_bus_wr_n;
  logic [2:0]  w_bus_addr;
  logic [15:0] w_bus_wdata;
  logic        r_cs;
  logic        r_wr_n;
  logic [2:0]  r_addr;
  logic [15:0] r_wdata;

  logic        r_done;
  logic [15:0] r_snap_l;
  logic [31:0] r_snap_value;

`ifdef TIMER_CTRL_MASTER_IRQ_SVC_EN
  logic             r_tick;
  logic [CNT_W-1:0] r_event_count;

  assign w_svc_req = irq;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tick        <= 1'b0;
      r_event_count <= '0;
    end else begin
      r_tick <= (r_state == ST_SVC_WR);
      if (r_state == ST_SVC_WR) begin
        r_event_count <= r_event_count + CNT_W'(1);
      end
    end
  end

  assign tick        = r_tick;
  assign event_count = r_event_count;
`else
  logic w_irq_unused;

  assign w_irq_unused = irq;
  assign w_svc_req    = 1'b0;
  assign tick         = 1'b0;
  assign event_count  = '0;
`endif

  assign cmd_ready = (r_state == ST_IDLE) && !w_svc_req;
  assign w_accept  = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_svc_req) begin
          w_next_state = ST_SVC_WR;
        end else if (cmd_valid) begin
          case (cmd_op)
            c_op_start:    w_next_state = ST_WR_PL;
            c_op_stop:     w_next_state = ST_WR_STOP;
            c_op_snapshot: w_next_state = ST_WR_SNAP;
            c_op_clear:    w_next_state = ST_WR_STAT;
            default:       w_next_state = ST_IDLE;
          endcase
        end
      end
      ST_WR_PL:   w_next_state = ST_WR_PH;
      ST_WR_PH:   w_next_state = ST_WR_CTRL;
      ST_WR_SNAP: w_next_state = ST_RD_SL;
      ST_RD_SL:   w_next_state = ST_RD_SH;
      ST_RD_SH:   w_next_state = ST_RD_LAST;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Bus fields are decoded from the next state and registered, so each access
  // is visible during its own state; address/writedata hold between accesses.
  always_comb begin
    w_bus_cs    = 1'b0;
    w_bus_wr_n  = 1'b1;
    w_bus_addr  = r_addr;
    w_bus_wdata = r_wdata;
    case (w_next_state)
      ST_WR_PL: begin
        // Only entered on acceptance, before the operands are latched.
        w_bus_cs    = 1'b1;
        w_bus_wr_n  = 1'b0;
        w_bus_addr  = c_reg_periodl;
        w_bus_wdata = cmd_period[15:0];
      end
      ST_WR_PH: begin
        w_bus_cs    = 1'b1;
        w_bus_wr_n  = 1'b0;
        w_bus_addr  = c_reg_periodh;
        w_bus_wdata = r_period_h;
      end
      ST_WR_CTRL: begin
        w_bus_cs    = 1'b1;
        w_bus_wr_n  = 1'b0;
        w_bus_addr  = c_reg_control;
        w_bus_wdata = ctrl_word(1'b0, 1'b1, r_cont, r_ito);
      end
      ST_WR_STOP: begin
        w_bus_cs    = 1'b1;
        w_bus_wr_n  = 1'b0;
        w_bus_addr  = c_reg_control;
        w_bus_wdata = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
      end
      ST_WR_STAT, ST_SVC_WR: begin
        w_bus_cs    = 1'b1;
        w_bus_wr_n  = 1'b0;
        w_bus_addr  = c_reg_status;
        w_bus_wdata = 16'h0000;
      end
      ST_WR_SNAP: begin
        w_bus_cs    = 1'b1;
        w_bus_wr_n  = 1'b0;
        w_bus_addr  = c_reg_snapl;
        w_bus_wdata = 16'h0000;
      end
      ST_RD_SL: begin
        w_bus_cs   = 1'b1;
        w_bus_addr = c_reg_snapl;
      end
      ST_RD_SH: begin
        w_bus_cs   = 1'b1;
        w_bus_addr = c_reg_snaph;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cs         <= 1'b0;
      r_wr_n       <= 1'b1;
      r_addr       <= 3'd0;
      r_wdata      <= 16'h0000;
      r_done       <= 1'b0;
      r_period_h   <= 16'h0000;
      r_cont       <= 1'b0;
      r_ito        <= 1'b0;
      r_snap_l     <= 16'h0000;
      r_snap_value <= 32'h0000_0000;
    end else begin
      r_cs    <= w_bus_cs;
      r_wr_n  <= w_bus_wr_n;
      r_addr  <= w_bus_addr;
      r_wdata <= w_bus_wdata;
      r_done  <= (r_state == ST_WR_CTRL) || (r_state == ST_WR_STOP) ||
                 (r_state == ST_WR_STAT) || (r_state == ST_RD_SH);
      if (w_accept) begin
        r_period_h <= cmd_period[31:16];
        r_cont     <= cmd_continuous;
        r_ito      <= cmd_irq_en;
      end
      // Read data trails its address by one cycle.
      if (r_state == ST_RD_SH) begin
        r_snap_l <= avm_readdata;
      end
      if (r_state == ST_RD_LAST) begin
        r_snap_value <= {avm_readdata, r_snap_l};
      end
    end
  end

  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wr_n;
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;
  assign cmd_done       = r_done;
  assign snap_value     = r_snap_value;

endmodule
`default_nettype wire

// File: tb/tb_first_system_timer_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_first_system_timer_ctrl_master
// Purpose  : Directed bench with a registered-readdata timer slave model
// Revision : 1.0  initial release
// ============================================================================
module tb_first_system_timer_ctrl_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_continuous;
  logic        cmd_irq_en;
  logic        cmd_done;
  logic [31:0] snap_value;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        irq = 1'b0;
  logic        tick;
  logic [15:0] event_count;

  logic        irq_raise;
  logic [31:0] model_cnt;
  logic [31:0] model_snap = 32'h0;
  logic [15:0] rdata = 16'h0;

  int          cyc = 0;
  int          tick_cnt = 0;
  logic [31:0] log_acc [0:255];
  int          log_cyc [0:255];
  int          log_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  first_system_timer_ctrl_master #(.CNT_W(16), .RD_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .cmd_irq_en(cmd_irq_en), .cmd_done(cmd_done), .snap_value(snap_value),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .irq(irq), .tick(tick), .event_count(event_count)
  );

  assign avm_readdata = rdata;

  // Timer slave: write a4 latches the counter, reads are registered, a0 write clears irq.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_chipselect && !avm_write_n && avm_address == 3'd4) model_snap <= model_cnt;
    if (avm_chipselect && avm_write_n)
      rdata <= (avm_address == 3'd4) ? model_snap[15:0] :
               (avm_address == 3'd5) ? model_snap[31:16] : 16'h0;
    if (avm_chipselect && !avm_write_n && avm_address == 3'd0) irq <= 1'b0;
    else if (irq_raise) irq <= 1'b1;
  end

  function automatic logic [31:0] acc_word(input logic we, input logic [2:0] a, input logic [15:0] d);
    return {11'd0, we, 1'b0, a, d};
  endfunction

  always @(negedge clk) begin
    if (avm_chipselect && log_n < 256) begin
      log_acc[log_n] <= acc_word(!avm_write_n, avm_address, avm_write_n ? 16'h0 : avm_writedata);
      log_cyc[log_n] <= cyc;
      log_n          <= log_n + 1;
    end
    if (tick) tick_cnt <= tick_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_acc(input string tag, input int idx, input int acc, input int off,
                           input logic [31:0] exp, input logic chk_data);
    check_eq({tag, "_cyc"}, log_cyc[idx] - acc, off);
    check_eq({tag, "_bus"}, chk_data ? log_acc[idx] : (log_acc[idx] & 32'hFFFF_0000),
             chk_data ? exp : (exp & 32'hFFFF_0000));
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont,
                          input logic ito, output int acc);
    logic got;
    got = 1'b0;
    acc = -100;
    cmd_op = op; cmd_period = per; cmd_continuous = cont; cmd_irq_en = ito;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc;
        got = 1'b1;
        break;
      end
    end
    check_eq("accept", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    logic got;
    got = 1'b0;
    dc = -100;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_done) begin
        dc = cyc;
        got = 1'b1;
        break;
      end
    end
    check_eq("done_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, dc, base, t0, busy, start;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_period = 32'h0;
    cmd_continuous = 1'b0; cmd_irq_en = 1'b0; irq_raise = 1'b0; model_cnt = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cs",    {31'd0, avm_chipselect}, 32'd0);
    check_eq("rst_wr_n",  {31'd0, avm_write_n}, 32'd1);
    check_eq("rst_addr",  {29'd0, avm_address}, 32'd0);
    check_eq("rst_wdata", {16'd0, avm_writedata}, 32'd0);
    check_eq("rst_done",  {31'd0, cmd_done}, 32'd0);
    check_eq("rst_tick",  {31'd0, tick}, 32'd0);
    check_eq("rst_snap",  snap_value, 32'd0);
    check_eq("rst_evcnt", {16'd0, event_count}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // START with continuous + irq enable
    base = log_n;
    send_cmd(2'd0, 32'h0001_86A0, 1'b1, 1'b1, acc);
    @(negedge clk);
    check_eq("start_busy", {31'd0, cmd_ready}, 32'd0);
    wait_done(dc);
    check_eq("start_done_off", dc - acc, 32'd4);
    check_eq("start_nacc", log_n - base, 32'd3);
    check_acc("start_pl",   base,     acc, 1, acc_word(1'b1, 3'd2, 16'h86A0), 1'b1);
    check_acc("start_ph",   base + 1, acc, 2, acc_word(1'b1, 3'd3, 16'h0001), 1'b1);
    check_acc("start_ctrl", base + 2, acc, 3, acc_word(1'b1, 3'd1, 16'h0007), 1'b1);
    @(negedge clk);
    check_eq("hold_cs",    {31'd0, avm_chipselect}, 32'd0);
    check_eq("hold_addr",  {29'd0, avm_address}, 32'd1);
    check_eq("hold_wdata", {16'd0, avm_writedata}, 32'h0007);
    @(posedge clk); #1;

    // START one-shot, no irq, all-ones period
    base = log_n;
    send_cmd(2'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, acc);
    wait_done(dc);
    check_eq("start2_done_off", dc - acc, 32'd4);
    check_acc("start2_pl",   base,     acc, 1, acc_word(1'b1, 3'd2, 16'hFFFF), 1'b1);
    check_acc("start2_ph",   base + 1, acc, 2, acc_word(1'b1, 3'd3, 16'hFFFF), 1'b1);
    check_acc("start2_ctrl", base + 2, acc, 3, acc_word(1'b1, 3'd1, 16'h0004), 1'b1);
    @(posedge clk); #1;

    // STOP and CLEAR
    base = log_n;
    send_cmd(2'd1, 32'h0, 1'b0, 1'b0, acc);
    wait_done(dc);
    check_eq("stop_done_off", dc - acc, 32'd2);
    check_acc("stop_wr", base, acc, 1, acc_word(1'b1, 3'd1, 16'h0008), 1'b1);
    @(posedge clk); #1;
    base = log_n;
    send_cmd(2'd3, 32'h0, 1'b0, 1'b0, acc);
    wait_done(dc);
    check_eq("clear_done_off", dc - acc, 32'd2);
    check_acc("clear_wr", base, acc, 1, acc_word(1'b1, 3'd0, 16'h0000), 1'b1);
    @(posedge clk); #1;

    // SNAPSHOT
    model_cnt = 32'h1234_5678;
    base = log_n;
    send_cmd(2'd2, 32'h0, 1'b0, 1'b0, acc);
    wait_done(dc);
    check_eq("snap_done_off", dc - acc, 32'd4);
    check_acc("snap_wr", base,     acc, 1, acc_word(1'b1, 3'd4, 16'h0000), 1'b0);
    check_acc("snap_sl", base + 1, acc, 2, acc_word(1'b0, 3'd4, 16'h0000), 1'b0);
    check_acc("snap_sh", base + 2, acc, 3, acc_word(1'b0, 3'd5, 16'h0000), 1'b0);
    @(negedge clk);
    check_eq("snap_nacc", log_n - base, 32'd3);
    check_eq("snap_value1", snap_value, 32'h1234_5678);
    @(posedge clk); #1;

    model_cnt = 32'hABCD_0001;
    send_cmd(2'd2, 32'h0, 1'b0, 1'b0, acc);
    wait_done(dc);
    @(posedge clk); #1;
    send_cmd(2'd1, 32'h0, 1'b0, 1'b0, acc);
    wait_done(dc);
    check_eq("snap_value2_held", snap_value, 32'hABCD_0001);
    @(posedge clk); #1;

    // Reset while RD_SL is on the bus
    model_cnt = 32'h5555_AAAA;
    base = log_n;
    send_cmd(2'd2, 32'h0, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rd_sl", {28'd0, avm_chipselect, avm_write_n, avm_address[2:1]}, 32'h0000_000E);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("mid_cs",    {31'd0, avm_chipselect}, 32'd0);
    check_eq("mid_snap",  snap_value, 32'd0);
    check_eq("mid_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (5) @(negedge clk);
    check_eq("mid_nacc", log_n - base, 32'd2);
    @(posedge clk); #1;

`ifdef TIMER_CTRL_MASTER_IRQ_SVC_EN
    // irq and STOP together: service first
    base = log_n; t0 = tick_cnt;
    irq_raise = 1'b1;
    @(posedge clk); #1;
    irq_raise = 1'b0;
    send_cmd(2'd1, 32'h0, 1'b0, 1'b0, acc);
    wait_done(dc);
    check_eq("svc_nacc", log_n - base, 32'd2);
    check_eq("svc_first", log_acc[base], acc_word(1'b1, 3'd0, 16'h0000));
    check_acc("svc_stop", base + 1, log_cyc[base], 2, acc_word(1'b1, 3'd1, 16'h0008), 1'b1);
    check_eq("svc_evcnt", {16'd0, event_count}, 32'd1);
    check_eq("svc_ticks", tick_cnt - t0, 32'd1);
    @(posedge clk); #1;

    // irq during START is deferred
    base = log_n; t0 = tick_cnt;
    send_cmd(2'd0, 32'h0000_0010, 1'b0, 1'b1, acc);
    irq_raise = 1'b1;
    @(posedge clk); #1;
    irq_raise = 1'b0;
    wait_done(dc);
    check_eq("defer_done_off", dc - acc, 32'd4);
    repeat (4) @(negedge clk);
    check_eq("defer_nacc", log_n - base, 32'd4);
    check_acc("defer_ctrl", base + 2, acc, 3, acc_word(1'b1, 3'd1, 16'h0005), 1'b1);
    check_acc("defer_svc",  base + 3, acc, 5, acc_word(1'b1, 3'd0, 16'h0000), 1'b1);
    check_eq("defer_evcnt", {16'd0, event_count}, 32'd2);
    check_eq("defer_ticks", tick_cnt - t0, 32'd1);
    @(posedge clk); #1;
`else
    // irq ignored: held high, no service, ready stays up
    base = log_n; t0 = tick_cnt; busy = 0;
    irq_raise = 1'b1;
    repeat (21) begin
      @(negedge clk);
      if (!cmd_ready) busy++;
    end
    @(posedge clk); #1;
    irq_raise = 1'b0;
    check_eq("noirq_busy",  busy, 32'd0);
    check_eq("noirq_nacc",  log_n - base, 32'd0);
    check_eq("noirq_ticks", tick_cnt - t0, 32'd0);
    check_eq("noirq_evcnt", {16'd0, event_count}, 32'd0);
    check_eq("noirq_level", {31'd0, irq}, 32'd1);
    start = cyc;
    send_cmd(2'd1, 32'h0, 1'b0, 1'b0, acc);
    check_eq("noirq_accept_now", acc - start, 32'd0);
    wait_done(dc);
    @(posedge clk); #1;
    send_cmd(2'd3, 32'h0, 1'b0, 1'b0, acc);
    wait_done(dc);
    @(negedge clk);
    check_eq("noirq_cleared", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
